// File: rtl/trap_controller_if.sv
// Trap controller bus: decoder/PC-side inputs and the redirected PC select, EPC and debug status.
interface trap_controller_if #(
    parameter int TRAP_CNT_W = 16
);
    logic [31:0]           PC;
    logic [31:0]           PCplus4;
    logic [2:0]            pcsrc_in;
    logic                  illop_in;
    logic                  eret_in;
    logic                  irq_in;
    logic                  irq_en;
    logic [2:0]            PCSrc;
    logic                  epc_wr;
    logic [31:0]           EPC;
    logic                  in_handler;
    logic                  irq_pending;
    logic                  double_fault;
    logic [TRAP_CNT_W-1:0] trap_count;

    modport master (
        output PC, PCplus4, pcsrc_in, illop_in, eret_in, irq_in, irq_en,
        input  PCSrc, epc_wr, EPC, in_handler, irq_pending, double_fault, trap_count
    );

    modport slave (
        input  PC, PCplus4, pcsrc_in, illop_in, eret_in, irq_in, irq_en,
        output PCSrc, epc_wr, EPC, in_handler, irq_pending, double_fault, trap_count
    );
endinterface

// File: rtl/trap_controller.sv
// Trap arbitration ahead of the PC register: illop > irq > decoder select; PCSrc/EPC combinational,
// mode/pending/counters update on the next edge. No backpressure: one instruction retires per clock.
module trap_controller #(
    parameter int TRAP_CNT_W  = 16,
    parameter int HOLDOFF_CYC = 1
) (
    input logic               clk,
    input logic               reset,
    trap_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_HANDLER = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_USER    = 2'd2
    } state_t;

    localparam logic [TRAP_CNT_W-1:0] CNT_ONE = {{(TRAP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]            HOLD_INIT = 4'(HOLDOFF_CYC);

    state_t                state_q, state_d;
    logic [3:0]            hold_q, hold_d;
    logic                  irq_prev_q;
    logic                  irq_pend_q, irq_pend_d;
    logic                  dfault_q, dfault_d;
    logic [TRAP_CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    logic                  take_ill, take_irq, irq_rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_HANDLER;
            hold_q     <= 4'd0;
            irq_prev_q <= 1'b0;
            irq_pend_q <= 1'b0;
            dfault_q   <= 1'b0;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            irq_prev_q <= bus.irq_in;
            irq_pend_q <= irq_pend_d;
            dfault_q   <= dfault_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        dfault_d   = dfault_q;
        trap_cnt_d = trap_cnt_q;

        take_ill = bus.illop_in;
        take_irq = irq_pend_q & bus.irq_en & (state_q == ST_USER) & ~bus.PC[31] & ~bus.illop_in;
        irq_rise = bus.irq_in & ~irq_prev_q;
        // A fresh edge in the same cycle as a take re-arms the request.
        irq_pend_d = irq_rise | (irq_pend_q & ~take_irq);

        bus.epc_wr = take_ill | take_irq;
        bus.EPC    = take_irq ? bus.PC : bus.PCplus4;
        if (take_ill)      bus.PCSrc = 3'd4;
        else if (take_irq) bus.PCSrc = 3'd5;
        else               bus.PCSrc = bus.pcsrc_in;

        if ((take_ill || take_irq) && (trap_cnt_q != '1))
            trap_cnt_d = trap_cnt_q + CNT_ONE;

        case (state_q)
            ST_USER: begin
                if (take_ill || take_irq) state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (take_ill) begin
                    dfault_d = 1'b1;
                end else if (bus.eret_in) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLDOFF: begin
                if (take_ill) begin
                    state_d = ST_HANDLER;
                end else if (hold_q <= 4'd1) begin
                    state_d = ST_USER;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = ST_HANDLER;
        endcase

        bus.in_handler   = (state_q == ST_HANDLER);
        bus.irq_pending  = irq_pend_q;
        bus.double_fault = dfault_q;
        bus.trap_count   = trap_cnt_q;
    end
endmodule
